nearest_upscale_x3: RTL



---
 rtl/nearest_pkg.sv | 19 +
 rtl/nearest_line_buf.sv | 25 ++
 rtl/nearest_upscale_x3.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/nearest_pkg.sv
// Shared types, defaults and width helper for the nearest-neighbour upscaler.
package nearest_pkg;

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

   localparam int DEF_DW    = 8;
   localparam int DEF_IMG_W = 64;
   localparam int DEF_IMG_H = 48;
   localparam int DEF_SCALE = 3;

   // Counter width for a 0..range-1 counter; never narrower than one bit.
   function automatic int cnt_w(input int range);
      return (range > 1) ? $clog2(range) : 1;
   endfunction

endpackage

// File: rtl/nearest_line_buf.sv
// Simple dual-port line buffer: synchronous write, registered read.
module nearest_line_buf #(
   parameter int DW    = 8,
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   // NOTE: storage and read register carry no reset so this maps onto block RAM;
   // validity of rdata is tracked by a reset flop in the parent.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/nearest_upscale_x3.sv
// Streaming nearest-neighbour upscaler: each input pixel becomes a SCALE x SCALE
// output block. Buffers one input line, then replays it SCALE times.
module nearest_upscale_x3 import nearest_pkg::*; #(
   parameter int DW    = DEF_DW,
   parameter int IMG_W = DEF_IMG_W,
   parameter int IMG_H = DEF_IMG_H,
   parameter int SCALE = DEF_SCALE
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic          in_sof,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_sof,
   output logic          out_eol,
   output logic          out_eof,
   output logic          busy
);

   localparam int CW = cnt_w(IMG_W);
   localparam int LW = cnt_w(IMG_H);
   localparam int HW = cnt_w(SCALE);
   localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
   localparam logic [LW-1:0] LINE_LAST = LW'(IMG_H - 1);
   localparam logic [HW-1:0] PH_LAST   = HW'(SCALE - 1);

   typedef struct packed {
      logic sof;
      logic eol;
      logic eof;
      logic last;
   } meta_t;

   typedef struct packed {
      logic [DW-1:0] data;
      meta_t         m;
   } pix_t;

   state_t        state, state_n;
   logic          started;
   logic [CW-1:0] col, rcol;
   logic [LW-1:0] line;
   logic [HW-1:0] hphase, vrep;
   logic          issue_done;

   logic          accept, issue, pop, pop_fifo, push, frame_end;
   logic [2:0]    occ_next;
   meta_t         issue_meta, rd_meta;
   logic          rd_valid;
   logic [DW-1:0] rd_data;
   pix_t          fifo0, fifo1, fifo0_n, fifo1_n, head;
   logic [1:0]    fifo_cnt, fifo_cnt_n;

   nearest_line_buf #(.DW(DW), .DEPTH(IMG_W), .AW(CW)) u_buf (
      .clk   (clk),
      .we    (accept),
      .waddr (in_sof ? '0 : col),
      .wdata (in_data),
      .re    (issue),
      .raddr (rcol),
      .rdata (rd_data)
   );

   // Output head: skid entry when present, otherwise bypass straight from the RAM read.
   assign head      = (fifo_cnt != 2'd0) ? fifo0 : {rd_data, rd_meta};
   assign out_valid = (fifo_cnt != 2'd0) || rd_valid;
   assign pop       = out_valid && out_ready;
   assign pop_fifo  = pop && (fifo_cnt != 2'd0);
   assign push      = rd_valid && !(pop && (fifo_cnt == 2'd0));
   assign frame_end = pop && head.m.last;
   assign accept    = in_valid && in_ready;

   assign out_data  = out_valid ? head.data  : '0;
   assign out_sof   = out_valid && head.m.sof;
   assign out_eol   = out_valid && head.m.eol;
   assign out_eof   = out_valid && head.m.eof;
   assign busy      = !(state == ST_LOAD && col == '0 && line == '0);

   // Issue only if the skid plus the in-flight read can still hold the result.
   assign occ_next = {1'b0, fifo_cnt} + {2'b0, rd_valid} - {2'b0, pop};
   assign issue    = (state == ST_EMIT) && !issue_done && (occ_next <= 3'd1);

   always_comb begin
      issue_meta.eol  = (rcol == COL_LAST) && (hphase == PH_LAST);
      issue_meta.last = issue_meta.eol && (vrep == PH_LAST);
      issue_meta.eof  = issue_meta.last && (line == LINE_LAST);
      issue_meta.sof  = (line == '0) && (vrep == '0) && (rcol == '0) && (hphase == '0);
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_n  = state;
      in_ready = 1'b0;
      case (state)
         ST_LOAD: begin
            in_ready = started;
            if (accept && !in_sof && col == COL_LAST) state_n = ST_EMIT;
         end
         ST_EMIT: begin
            if (frame_end) state_n = ST_LOAD;
         end
         default: state_n = ST_LOAD;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_LOAD;
         started <= 1'b0;
      end else begin
         state   <= state_n;
         started <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col  <= '0;
         line <= '0;
      end else begin
         if (accept) begin
            if (in_sof) begin
               col  <= CW'(1);
               line <= '0;
            end else begin
               col <= (col == COL_LAST) ? '0 : col + CW'(1);
            end
         end
         if (frame_end) line <= (line == LINE_LAST) ? '0 : line + LW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hphase     <= '0;
         rcol       <= '0;
         vrep       <= '0;
         issue_done <= 1'b0;
         rd_valid   <= 1'b0;
         rd_meta    <= '0;
      end else begin
         rd_valid <= issue;
         if (issue) begin
            rd_meta    <= issue_meta;
            issue_done <= issue_meta.last;
            if (hphase == PH_LAST) begin
               hphase <= '0;
               if (rcol == COL_LAST) begin
                  rcol <= '0;
                  vrep <= (vrep == PH_LAST) ? '0 : vrep + HW'(1);
               end else begin
                  rcol <= rcol + CW'(1);
               end
            end else begin
               hphase <= hphase + HW'(1);
            end
         end
         if (frame_end) issue_done <= 1'b0;
      end
   end

   always_comb begin
      fifo0_n    = fifo0;
      fifo1_n    = fifo1;
      fifo_cnt_n = fifo_cnt;
      if (pop_fifo) begin
         fifo0_n    = fifo1;
         fifo_cnt_n = fifo_cnt - 2'd1;
      end
      if (push) begin
         if (fifo_cnt_n == 2'd0) fifo0_n = {rd_data, rd_meta};
         else                    fifo1_n = {rd_data, rd_meta};
         fifo_cnt_n = fifo_cnt_n + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo0    <= '0;
         fifo1    <= '0;
         fifo_cnt <= 2'd0;
      end else begin
         fifo0    <= fifo0_n;
         fifo1    <= fifo1_n;
         fifo_cnt <= fifo_cnt_n;
      end
   end

endmodule
